mem_arbiter_nch: RTL and testbench
==================================

// Module: mem_arbiter_nch
// PURPOSE
//   N-channel arbiter merging the pmem ports of up to N L1 caches (I$, D$, future
//   prefetch/DMA) onto the single request port of the L2 cache.
//   Generalises the fixed two-port I/D arbiter. Adds a selectable fixed-priority or
//   round-robin policy, latched request fields, a post-response release cycle,
//   and per-channel grant counters for performance monitoring.
// PARAMETERS
//   N_CH      2    number of requesting channels (2..8)
//   ADDR_W    16   address width (lc3b_word)
//   LINE_W    128  cache-line data width (lc3b_mem_data)
//   RR_MODE   1    1 = round-robin; 0 = fixed priority, channel 0 highest
//   CNT_W     16   width of each grant counter
// PORTS
//   clk          in   1             system clock, all state on rising edge
//   rst_n        in   1             asynchronous, active-low reset
//   ch_read      in   N_CH          per-channel line read request
//   ch_write     in   N_CH          per-channel line write request
//   ch_address   in   N_CH*ADDR_W   per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata     in   N_CH*LINE_W   per-channel write line, channel i at [i*LINE_W +: LINE_W]
//   ch_resp      out  N_CH          one-hot completion pulse to the granted channel
//   ch_rdata     out  LINE_W        read line, shared by all channels
//   l2_read      out  1             read request to L2
//   l2_write     out  1             write request to L2
//   l2_address   out  ADDR_W        latched address of the granted request
//   l2_wdata     out  LINE_W        latched write line of the granted request
//   l2_resp      in   1             L2 completion
//   l2_rdata     in   LINE_W        L2 read line
//   busy         out  1             high in GRANT or RELEASE
//   grant_id     out  $clog2(N_CH)  index of the current or last granted channel
//   grant_cnt    out  N_CH*CNT_W    per-channel count of completed transactions
// BEHAVIOUR
//   Reset values: every output is 0, state is IDLE, rr_ptr is 0, and all counters are 0.
//   FSM
//     IDLE
//       - If any channel has ch_read or ch_write high, pick a winner and go to GRANT.
//       - On entry to GRANT, latch op, address, wdata and grant_id.
//     GRANT
//       - Drive l2_read/l2_write from the latched op. Drive l2_address/l2_wdata from the latches.
//       - Hold these outputs stable until l2_resp.
//       - When l2_resp=1: assert ch_resp[grant_id]=1 combinationally in the same cycle,
//         increment grant_cnt[grant_id] (wraps at 2^CNT_W), then go to RELEASE.
//     RELEASE
//       - Lasts exactly 1 cycle. l2_read, l2_write and ch_resp are all 0. Then go to IDLE.
//       - Purpose: the finishing channel drops its request before the next arbitration,
//         so it is never re-granted a stale request.
//   Latency
//     - A request first seen in IDLE at cycle t gives l2_read/l2_write=1 at cycle t+1.
//     - Minimum spacing between back-to-back grants: l2 latency + 2 cycles.
//   ch_rdata = l2_rdata at all times. It is valid only while ch_resp is asserted.
//   Arbitration policy
//     - RR_MODE=1: search starts at rr_ptr and wraps modulo N_CH. On grant,
//       rr_ptr <= (winner + 1) mod N_CH.
//     - RR_MODE=0: lowest asserted index wins. rr_ptr is unused.
//   Edge cases
//     - ch_read and ch_write both high on one channel: treated as a write.
//     - A channel deasserting its request mid-GRANT is ignored. The latched transaction
//       completes and ch_resp still pulses. Requesters must hold until resp.
//     - l2_resp in IDLE or RELEASE is ignored: no resp, no count.
//     - Requests arriving during GRANT or RELEASE wait. None are dropped.
//     - rst_n asserted mid-transaction returns to IDLE immediately (asynchronous).
//       Outputs go to 0 and the in-flight transaction is abandoned.
// STRUCTURE
//   Package lc3b_types
//     - lc3b_word and lc3b_mem_data already live there.
//     - Add arb_state_t enum {ARB_IDLE, ARB_GRANT, ARB_RELEASE}.
//   Sub-module rr_picker #(N_CH, RR_MODE)
//     - Purely combinational: (req vector, rr_ptr) -> (valid, winner index).
//   The FSM, latches and counters stay in this module.
// TESTING (N_CH=2 unless noted; L2 model answers 3 cycles after request)
//   1. ch0 read 0x1230 alone -> l2_read=1 with addr 0x1230 at t+1; ch_resp=2'b01 after 3 cycles; RELEASE then IDLE.
//   2. RR_MODE=1, ch0 and ch1 both request continuously -> grants go 0,1,0,1; grant_cnt 2/2 after 4 transactions.
//   3. RR_MODE=0, both request continuously -> ch0 is granted every time; ch1 only after ch0 drops.
//   4. ch1 write, wdata=128'hA5.., drops ch_write during GRANT -> l2_write held with latched data; ch_resp=2'b10 still fires.
//   5. rst_n low 1 cycle into GRANT -> l2_read=0 immediately; state IDLE; counters 0; next request is granted normally.
//   6. N_CH=4, RR_MODE=1, ch1 and ch3 request, rr_ptr=2 -> ch3 wins, then ch1; a spurious l2_resp in IDLE produces no ch_resp.

Source files
------------

// File: rtl/mem_arbiter_nch_pkg.sv
// Shared types for the N-channel L1 -> L2 memory arbiter.
//   lc3b_word / lc3b_mem_data : address and cache-line types of the LC-3b memory system
//   arb_state_t               : arbiter FSM state, also exported on the top's debug port
package mem_arbiter_nch_pkg;

  localparam int LC3B_WORD_W = 16;
  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_mem_data;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_nch_if.sv
// Bus bundle between N L1 request ports, the arbiter and the single L2 port.
//   ch_read/ch_write/ch_address/ch_wdata : per-channel requests (channel i at slice i)
//   ch_resp/ch_rdata                     : one-hot completion pulse and shared read line
//   l2_read/l2_write/l2_address/l2_wdata : merged request towards L2
//   l2_resp/l2_rdata                     : L2 completion and read line
// Handshake: a request (ch_read|ch_write, or l2_read|l2_write) is the "valid" and
// the matching resp pulse is the "ready"; the requester holds the request and its
// address/data stable until the cycle in which resp is high, and the transfer
// completes in exactly that cycle.
// Modports: master = arbiter side, slave = caches + L2 side.
interface mem_arbiter_nch_if
  import mem_arbiter_nch_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADDR_W = LC3B_WORD_W,
  parameter int LINE_W = LC3B_LINE_W
);
  logic [N_CH-1:0]        ch_read;
  logic [N_CH-1:0]        ch_write;
  logic [N_CH*ADDR_W-1:0] ch_address;
  logic [N_CH*LINE_W-1:0] ch_wdata;
  logic [N_CH-1:0]        ch_resp;
  logic [LINE_W-1:0]      ch_rdata;
  logic                   l2_read;
  logic                   l2_write;
  logic [ADDR_W-1:0]      l2_address;
  logic [LINE_W-1:0]      l2_wdata;
  logic                   l2_resp;
  logic [LINE_W-1:0]      l2_rdata;

  modport master (
    input  ch_read, ch_write, ch_address, ch_wdata, l2_resp, l2_rdata,
    output ch_resp, ch_rdata, l2_read, l2_write, l2_address, l2_wdata
  );

  modport slave (
    output ch_read, ch_write, ch_address, ch_wdata, l2_resp, l2_rdata,
    input  ch_resp, ch_rdata, l2_read, l2_write, l2_address, l2_wdata
  );
endinterface

// File: rtl/mem_arbiter_nch_rr_picker.sv
// Combinational winner selection.
//   req    : per-channel request vector
//   rr_ptr : first channel to consider (round-robin only)
//   valid  : at least one request present
//   winner : index of the selected channel
// RR_MODE != 0 scans rr_ptr, rr_ptr+1, ... wrapping modulo N_CH; RR_MODE == 0
// scans from channel 0, giving fixed priority to the lowest index.
module mem_arbiter_nch_rr_picker #(
  parameter int N_CH    = 2,
  parameter int RR_MODE = 1,
  localparam int ID_W   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            valid,
  output logic [ID_W-1:0] winner
);

  always_comb begin
    int base;
    int idx;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    base   = (RR_MODE != 0) ? int'(rr_ptr) : 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (base + k) % N_CH;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_nch.sv
// N-channel arbiter merging L1 cache pmem ports onto one L2 request port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : channel and L2 signals (mem_arbiter_nch_if.master)
//   busy       : high while in GRANT or RELEASE
//   grant_id   : current or most recently granted channel
//   grant_cnt  : per-channel completed-transaction counters, channel i at [i*CNT_W +: CNT_W]
//   state      : FSM state for debug/observation
// Flow: IDLE picks a winner and latches its op/address/wdata, GRANT holds the L2
// request until l2_resp (ch_resp pulses combinationally in that cycle), RELEASE
// spends one cycle so the finished requester can drop before re-arbitration.
module mem_arbiter_nch
  import mem_arbiter_nch_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = LC3B_WORD_W,
  parameter int LINE_W  = LC3B_LINE_W,
  parameter int RR_MODE = 1,
  parameter int CNT_W   = 16,
  localparam int ID_W   = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_arbiter_nch_if.master     bus,
  output logic                  busy,
  output logic [ID_W-1:0]       grant_id,
  output logic [N_CH*CNT_W-1:0] grant_cnt,
  output arb_state_t            state
);

  arb_state_t        state_q;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   pick_id;
  logic              pick_valid;
  logic              busy_q;
  logic              l2_read_q;
  logic              l2_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q [N_CH];
  logic [N_CH-1:0]   req;
  logic              done;

  assign req = bus.ch_read | bus.ch_write;

  mem_arbiter_nch_rr_picker #(
    .N_CH    (N_CH),
    .RR_MODE (RR_MODE)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  // l2_resp only completes a transaction while one is actually outstanding.
  assign done = (state_q == ARB_GRANT) && bus.l2_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr     <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            state_q    <= ARB_GRANT;
            busy_q     <= 1'b1;
            grant_q    <= pick_id;
            // read+write on one channel resolves to a write
            l2_write_q <= bus.ch_write[pick_id];
            l2_read_q  <= ~bus.ch_write[pick_id];
            addr_q     <= bus.ch_address[pick_id*ADDR_W +: ADDR_W];
            wdata_q    <= bus.ch_wdata[pick_id*LINE_W +: LINE_W];
            if (RR_MODE != 0) rr_ptr <= ID_W'((int'(pick_id) + 1) % N_CH);
          end
        end
        ARB_GRANT: begin
          if (bus.l2_resp) begin
            state_q          <= ARB_RELEASE;
            l2_read_q        <= 1'b0;
            l2_write_q       <= 1'b0;
            cnt_q[grant_q]   <= cnt_q[grant_q] + 1'b1;
          end
        end
        ARB_RELEASE: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.ch_resp    = done ? (N_CH'(1) << grant_q) : '0;
  assign bus.ch_rdata   = bus.l2_rdata;
  assign bus.l2_read    = l2_read_q;
  assign bus.l2_write   = l2_write_q;
  assign bus.l2_address = addr_q;
  assign bus.l2_wdata   = wdata_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_cnt
    assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Bench for mem_arbiter_nch: three instances (2ch round-robin, 2ch fixed
// priority, 4ch round-robin) driven through uniform per-instance arrays.
module tb_mem_arbiter_nch;
  import mem_arbiter_nch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- per-instance stimulus / observation ----------------
  logic [3:0]        t_read   [3];
  logic [3:0]        t_write  [3];
  logic [3:0][15:0]  t_addr   [3];
  logic [3:0][127:0] t_wdata  [3];
  logic              t_l2_resp[3];
  logic [127:0]      t_l2_rdata[3];

  logic [3:0]        o_resp   [3];
  logic [127:0]      o_rdata  [3];
  logic              o_l2_rd  [3];
  logic              o_l2_wr  [3];
  logic [15:0]       o_l2_addr[3];
  logic [127:0]      o_l2_wd  [3];
  logic              o_busy   [3];
  logic [1:0]        o_gid    [3];
  logic [3:0][15:0]  o_cnt    [3];
  arb_state_t        o_state  [3];

  wire [0:0]  gid0, gid1;
  wire [1:0]  gid2;
  wire [31:0] cnt0, cnt1;
  wire [63:0] cnt2;

  mem_arbiter_nch_if #(.N_CH(2)) b0 ();
  mem_arbiter_nch_if #(.N_CH(2)) b1 ();
  mem_arbiter_nch_if #(.N_CH(4)) b2 ();

  mem_arbiter_nch #(.N_CH(2), .RR_MODE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .busy(o_busy[0]),
    .grant_id(gid0), .grant_cnt(cnt0), .state(o_state[0]));
  mem_arbiter_nch #(.N_CH(2), .RR_MODE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .busy(o_busy[1]),
    .grant_id(gid1), .grant_cnt(cnt1), .state(o_state[1]));
  mem_arbiter_nch #(.N_CH(4), .RR_MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .busy(o_busy[2]),
    .grant_id(gid2), .grant_cnt(cnt2), .state(o_state[2]));

  assign b0.ch_read = t_read[0][1:0];   assign b0.ch_write = t_write[0][1:0];
  assign b0.ch_address = t_addr[0][1:0]; assign b0.ch_wdata = t_wdata[0][1:0];
  assign b0.l2_resp = t_l2_resp[0];     assign b0.l2_rdata = t_l2_rdata[0];
  assign b1.ch_read = t_read[1][1:0];   assign b1.ch_write = t_write[1][1:0];
  assign b1.ch_address = t_addr[1][1:0]; assign b1.ch_wdata = t_wdata[1][1:0];
  assign b1.l2_resp = t_l2_resp[1];     assign b1.l2_rdata = t_l2_rdata[1];
  assign b2.ch_read = t_read[2];        assign b2.ch_write = t_write[2];
  assign b2.ch_address = t_addr[2];     assign b2.ch_wdata = t_wdata[2];
  assign b2.l2_resp = t_l2_resp[2];     assign b2.l2_rdata = t_l2_rdata[2];

  assign o_resp[0] = {2'b00, b0.ch_resp}; assign o_resp[1] = {2'b00, b1.ch_resp};
  assign o_resp[2] = b2.ch_resp;
  assign o_rdata[0] = b0.ch_rdata; assign o_rdata[1] = b1.ch_rdata; assign o_rdata[2] = b2.ch_rdata;
  assign o_l2_rd[0] = b0.l2_read;  assign o_l2_rd[1] = b1.l2_read;  assign o_l2_rd[2] = b2.l2_read;
  assign o_l2_wr[0] = b0.l2_write; assign o_l2_wr[1] = b1.l2_write; assign o_l2_wr[2] = b2.l2_write;
  assign o_l2_addr[0] = b0.l2_address; assign o_l2_addr[1] = b1.l2_address;
  assign o_l2_addr[2] = b2.l2_address;
  assign o_l2_wd[0] = b0.l2_wdata; assign o_l2_wd[1] = b1.l2_wdata; assign o_l2_wd[2] = b2.l2_wdata;
  assign o_gid[0] = {1'b0, gid0};  assign o_gid[1] = {1'b0, gid1};  assign o_gid[2] = gid2;
  assign o_cnt[0] = {32'd0, cnt0}; assign o_cnt[1] = {32'd0, cnt1}; assign o_cnt[2] = cnt2;

  // ---------------- reference model ----------------
  int last_served[3];   // channel that completed most recently (-1 = none since reset)
  int cnt_m[3][4];      // completed transactions per channel
  int checks = 0;
  int errors = 0;

  function automatic int n_of(input int k);
    return (k == 2) ? 4 : 2;
  endfunction

  function automatic int rr_of(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  // Fixed priority: lowest requesting channel. Round-robin: first requester
  // strictly after the last served one, in cyclic order.
  function automatic int model_pick(input int k, input logic [3:0] req);
    int n;
    int idx;
    n = n_of(k);
    for (int off = 0; off < n; off++) begin
      idx = (rr_of(k) != 0) ? (last_served[k] + 1 + off) % n : off;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      last_served[k] = -1;
      for (int i = 0; i < 4; i++) cnt_m[k][i] = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input int k, input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL dut%0d %s observed=%0h expected=%0h", k, tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input int k);
    chk(k, "rst_state", o_state[k], ARB_IDLE);
    chk(k, "rst_l2_read", o_l2_rd[k], 0);
    chk(k, "rst_l2_write", o_l2_wr[k], 0);
    chk(k, "rst_l2_address", o_l2_addr[k], 0);
    chk(k, "rst_l2_wdata", o_l2_wd[k], 0);
    chk(k, "rst_ch_resp", o_resp[k], 0);
    chk(k, "rst_busy", o_busy[k], 0);
    chk(k, "rst_grant_id", o_gid[k], 0);
    chk(k, "rst_grant_cnt", o_cnt[k], 0);
  endtask

  // ---------------- driver: one full transaction ----------------
  // Called at a negedge while instance k is IDLE with its requests applied.
  task automatic serve(input int k, input int lat, input bit drop_mid, input bit release_req);
    int win;
    logic w;
    logic [15:0] a;
    logic [127:0] d;
    logic [127:0] rd;
    win = model_pick(k, t_read[k] | t_write[k]);
    if (win < 0) return;
    w = t_write[k][win];
    a = t_addr[k][win];
    d = t_wdata[k][win];
    last_served[k] = win;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk(k, "state_grant", o_state[k], ARB_GRANT);
      chk(k, "l2_read", o_l2_rd[k], !w);
      chk(k, "l2_write", o_l2_wr[k], w);
      chk(k, "l2_address", o_l2_addr[k], a);
      if (w) chk(k, "l2_wdata", o_l2_wd[k], d);
      chk(k, "busy_grant", o_busy[k], 1);
      chk(k, "grant_id", o_gid[k], win);
      chk(k, "ch_resp_wait", o_resp[k], 0);
      if (drop_mid && c == 1) begin
        t_read[k][win]  = 1'b0;
        t_write[k][win] = 1'b0;
        t_addr[k][win]  = 16'($urandom);
        t_wdata[k][win] = {$urandom, $urandom, $urandom, $urandom};
      end
      if (c == lat) begin
        rd = {$urandom, $urandom, $urandom, $urandom};
        t_l2_resp[k]  = 1'b1;
        t_l2_rdata[k] = rd;
        #1;
        chk(k, "ch_resp", o_resp[k], 4'b0001 << win);
        chk(k, "ch_rdata", o_rdata[k], rd);
        if (release_req) begin
          t_read[k][win]  = 1'b0;
          t_write[k][win] = 1'b0;
        end
      end
    end
    cnt_m[k][win] = (cnt_m[k][win] + 1) & 16'hffff;
    @(negedge clk);
    // l2_resp is still high here: RELEASE must ignore it
    chk(k, "state_release", o_state[k], ARB_RELEASE);
    chk(k, "rel_l2_read", o_l2_rd[k], 0);
    chk(k, "rel_l2_write", o_l2_wr[k], 0);
    chk(k, "rel_ch_resp", o_resp[k], 0);
    chk(k, "rel_busy", o_busy[k], 1);
    for (int i = 0; i < n_of(k); i++) chk(k, "grant_cnt", o_cnt[k][i], 16'(cnt_m[k][i]));
    @(negedge clk);
    t_l2_resp[k] = 1'b0;
    chk(k, "state_idle", o_state[k], ARB_IDLE);
    chk(k, "idle_busy", o_busy[k], 0);
    chk(k, "idle_grant_id", o_gid[k], win);
    for (int i = 0; i < n_of(k); i++) chk(k, "idle_cnt", o_cnt[k][i], 16'(cnt_m[k][i]));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [3:0] cur, nw, mask;
    int op;
    for (int k = 0; k < 3; k++) begin
      t_read[k] = '0; t_write[k] = '0; t_addr[k] = '0; t_wdata[k] = '0;
      t_l2_resp[k] = 1'b0; t_l2_rdata[k] = '0;
    end
    model_reset();

    #2;
    for (int k = 0; k < 3; k++) check_reset_outputs(k);
    @(negedge clk);
    rst_n = 1'b1;

    // ch0 read 0x1230 alone
    t_read[0][0] = 1'b1; t_addr[0][0] = 16'h1230;
    serve(0, 3, 1'b0, 1'b1);

    // round-robin, both channels requesting continuously
    t_read[0] = 4'b0011; t_addr[0][1] = 16'h4560;
    for (int i = 0; i < 4; i++) serve(0, 3, 1'b0, 1'b0);
    t_read[0] = 4'b0000;

    // ch1 write of an A5 line, dropped during GRANT
    t_write[0][1] = 1'b1; t_addr[0][1] = 16'hBEEF; t_wdata[0][1] = {16{8'hA5}};
    serve(0, 3, 1'b1, 1'b1);

    // fixed priority: ch0 wins while it keeps requesting, ch1 only after it drops
    t_read[1] = 4'b0011; t_addr[1][0] = 16'h0100; t_addr[1][1] = 16'h0200;
    serve(1, 3, 1'b0, 1'b0);
    serve(1, 3, 1'b0, 1'b0);
    serve(1, 3, 1'b0, 1'b1);
    serve(1, 3, 1'b0, 1'b1);

    // 4 channels: move the pointer to 2, then ch1 and ch3 compete
    t_read[2][1] = 1'b1; t_addr[2][1] = 16'h1111;
    serve(2, 2, 1'b0, 1'b1);
    t_read[2][1] = 1'b1; t_write[2][3] = 1'b1; t_read[2][3] = 1'b1;
    t_addr[2][3] = 16'h3333; t_wdata[2][3] = {4{32'hC0FFEE33}};
    serve(2, 3, 1'b0, 1'b1);
    serve(2, 3, 1'b0, 1'b1);
    // spurious l2_resp while IDLE
    t_l2_resp[2] = 1'b1;
    #1;
    chk(2, "spurious_resp", o_resp[2], 0);
    @(negedge clk);
    chk(2, "spurious_state", o_state[2], ARB_IDLE);
    chk(2, "spurious_cnt3", o_cnt[2][3], 16'(cnt_m[2][3]));
    chk(2, "spurious_cnt1", o_cnt[2][1], 16'(cnt_m[2][1]));
    t_l2_resp[2] = 1'b0;

    // asynchronous reset one cycle into GRANT
    t_read[0][0] = 1'b1; t_addr[0][0] = 16'h0BEE;
    @(negedge clk);
    chk(0, "pre_rst_l2_read", o_l2_rd[0], 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) check_reset_outputs(k);
    @(negedge clk);
    rst_n = 1'b1;
    serve(0, 3, 1'b0, 1'b1);

    // randomized traffic on every instance
    for (int k = 0; k < 3; k++) begin
      mask = (n_of(k) == 4) ? 4'b1111 : 4'b0011;
      for (int it = 0; it < 14; it++) begin
        cur = t_read[k] | t_write[k];
        nw  = 4'($urandom) & mask & ~cur;
        if ((cur | nw) == 4'b0000) nw = 4'b0001 << $urandom_range(n_of(k) - 1, 0);
        for (int ch = 0; ch < 4; ch++) begin
          if (nw[ch]) begin
            op = $urandom_range(2, 0);
            t_read[k][ch]  = (op != 1);
            t_write[k][ch] = (op != 0);
            t_addr[k][ch]  = 16'($urandom);
            t_wdata[k][ch] = {$urandom, $urandom, $urandom, $urandom};
          end
        end
        serve(k, $urandom_range(4, 1), ($urandom_range(3, 0) == 0), 1'b1);
      end
      t_read[k]  = '0;
      t_write[k] = '0;
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
